// File: rtl/pipelined_adder_if.sv
// Streaming handshake bundle for pipelined_adder: operand side (a/b/cin) and result side (s/cout/ovf).
// The ovf signal exists only when PIPELINED_ADDER_OVF_EN is defined.
interface pipelined_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
`ifdef PIPELINED_ADDER_OVF_EN
    logic             ovf;
`endif

    // Producer/consumer side (drives operands, accepts results)
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, s, cout
`ifdef PIPELINED_ADDER_OVF_EN
        , input ovf
`endif
    );

    // Adder side
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, s, cout
`ifdef PIPELINED_ADDER_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/pipelined_adder.sv
// WIDTH-bit adder split into WIDTH/CHUNK carry-chained stages with valid/ready backpressure.
// Define PIPELINED_ADDER_OVF_EN to add the registered signed-overflow output.
module pipelined_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    pipelined_adder_if.slave bus
);
    localparam int STAGES = (CHUNK > 0) ? WIDTH / CHUNK : 1;

    if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_cfg_check
        $error("pipelined_adder: WIDTH must be a positive multiple of CHUNK");
    end

    logic stall;
    logic advance;
    logic last_valid;

    // The whole pipeline freezes only when a finished result is waiting on the consumer.
    assign stall        = last_valid && !bus.out_ready;
    assign advance      = !stall;
    assign bus.in_ready = advance;

    for (genvar gi = 0; gi < STAGES; gi++) begin : stage
        logic [CHUNK-1:0]         a_chunk;
        logic [CHUNK-1:0]         b_chunk;
        logic                     carry_in;
        logic                     valid_in;
        logic [CHUNK:0]           chunk_sum;
        logic [(gi+1)*CHUNK-1:0]  sum_next;
        logic [(gi+1)*CHUNK-1:0]  sum_reg;
        logic                     carry_reg;
        logic                     valid_reg;
`ifdef PIPELINED_ADDER_OVF_EN
        logic                     sign_a_in;
        logic                     sign_b_in;
`endif

        if (gi == 0) begin : g_src
            assign a_chunk  = bus.a[CHUNK-1:0];
            assign b_chunk  = bus.b[CHUNK-1:0];
            assign carry_in = bus.cin;
            assign valid_in = bus.in_valid;
            assign sum_next = chunk_sum[CHUNK-1:0];
`ifdef PIPELINED_ADDER_OVF_EN
            assign sign_a_in = bus.a[WIDTH-1];
            assign sign_b_in = bus.b[WIDTH-1];
`endif
        end else begin : g_src
            // Lowest still-unprocessed chunk sits at the bottom of the previous skew register.
            assign a_chunk  = stage[gi-1].g_skew.a_hi_reg[CHUNK-1:0];
            assign b_chunk  = stage[gi-1].g_skew.b_hi_reg[CHUNK-1:0];
            assign carry_in = stage[gi-1].carry_reg;
            assign valid_in = stage[gi-1].valid_reg;
            assign sum_next = {chunk_sum[CHUNK-1:0], stage[gi-1].sum_reg};
`ifdef PIPELINED_ADDER_OVF_EN
            assign sign_a_in = stage[gi-1].g_skew.sign_a_reg;
            assign sign_b_in = stage[gi-1].g_skew.sign_b_reg;
`endif
        end

        assign chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_in};

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_reg <= 1'b0;
                carry_reg <= 1'b0;
                sum_reg   <= '0;
            end else if (advance) begin
                valid_reg <= valid_in;
                carry_reg <= chunk_sum[CHUNK];
                sum_reg   <= sum_next;
            end
        end

        if (gi < STAGES - 1) begin : g_skew
            localparam int HI_W = WIDTH - (gi + 1) * CHUNK;

            logic [HI_W-1:0] a_hi_next;
            logic [HI_W-1:0] b_hi_next;
            logic [HI_W-1:0] a_hi_reg;
            logic [HI_W-1:0] b_hi_reg;
`ifdef PIPELINED_ADDER_OVF_EN
            logic            sign_a_reg;
            logic            sign_b_reg;
`endif

            if (gi == 0) begin : g_hi_src
                assign a_hi_next = bus.a[WIDTH-1:CHUNK];
                assign b_hi_next = bus.b[WIDTH-1:CHUNK];
            end else begin : g_hi_src
                assign a_hi_next = stage[gi-1].g_skew.a_hi_reg[HI_W+CHUNK-1:CHUNK];
                assign b_hi_next = stage[gi-1].g_skew.b_hi_reg[HI_W+CHUNK-1:CHUNK];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_hi_reg <= '0;
                    b_hi_reg <= '0;
`ifdef PIPELINED_ADDER_OVF_EN
                    sign_a_reg <= 1'b0;
                    sign_b_reg <= 1'b0;
`endif
                end else if (advance) begin
                    a_hi_reg <= a_hi_next;
                    b_hi_reg <= b_hi_next;
`ifdef PIPELINED_ADDER_OVF_EN
                    sign_a_reg <= sign_a_in;
                    sign_b_reg <= sign_b_in;
`endif
                end
            end
        end

`ifdef PIPELINED_ADDER_OVF_EN
        if (gi == STAGES - 1) begin : g_ovf
            logic ovf_next;
            logic ovf_reg;

            // Same-sign operands whose result sign differs overflowed in two's complement.
            assign ovf_next = (sign_a_in == sign_b_in) && (sum_next[WIDTH-1] != sign_a_in);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_reg <= 1'b0;
                end else if (advance) begin
                    ovf_reg <= ovf_next;
                end
            end
        end
`endif
    end

    assign last_valid    = stage[STAGES-1].valid_reg;
    assign bus.out_valid = last_valid;
    assign bus.s         = stage[STAGES-1].sum_reg;
    assign bus.cout      = stage[STAGES-1].carry_reg;
`ifdef PIPELINED_ADDER_OVF_EN
    assign bus.ovf       = stage[STAGES-1].g_ovf.ovf_reg;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed and randomized checks of pipelined_adder (WIDTH=8, CHUNK=4) against a scoreboard of
// arithmetic reference results; ovf is checked when PIPELINED_ADDER_OVF_EN is defined.
module tb_pipelined_adder;
    localparam int WIDTH = 8;
    localparam int CHUNK = 4;

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             cout;
        logic             ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipelined_adder_if #(.WIDTH(WIDTH)) bus ();

    pipelined_adder #(
        .WIDTH(WIDTH),
        .CHUNK(CHUNK)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fails  = 0;
    logic consumed;
    logic accepted;
    int   idx;

    logic [7:0] ops_a [4] = '{8'h01, 8'h02, 8'h03, 8'h04};

    function automatic exp_t model(logic [7:0] a, logic [7:0] b, logic cin);
        logic [8:0] full;
        exp_t       e;
        full   = {1'b0, a} + {1'b0, b} + {8'h00, cin};
        e.s    = full[7:0];
        e.cout = full[8];
        e.ovf  = (a[7] == b[7]) && (full[7] != a[7]);
        return e;
    endfunction

    task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes at the falling edge, then return just after the rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        consumed = bus.out_valid && bus.out_ready;
        accepted = bus.in_valid && bus.in_ready;
        if (consumed) begin
            if (sb.size() == 0) begin
                check("spurious_out", {15'h0, bus.out_valid}, 16'h0);
            end else begin
                e = sb.pop_front();
                $display("out s=0x%02h cout=%0b (expected s=0x%02h cout=%0b)", bus.s, bus.cout, e.s, e.cout);
                check("sum", {8'h00, bus.s}, {8'h00, e.s});
                check("cout", {15'h0, bus.cout}, {15'h0, e.cout});
`ifdef PIPELINED_ADDER_OVF_EN
                check("ovf", {15'h0, bus.ovf}, {15'h0, e.ovf});
`endif
            end
        end
        if (accepted) sb.push_back(model(bus.a, bus.b, bus.cin));
        @(posedge clk);
        #1;
    endtask

    task automatic send(logic [7:0] a, logic [7:0] b, logic cin);
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (accepted) break;
        end
        check("accept", {15'h0, accepted}, 16'h1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 12 && sb.size() != 0; i++) tick();
        check("drain_empty", 16'(sb.size()), 16'h0);
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {15'h0, bus.out_valid}, 16'h0);
        check("rst_s", {8'h00, bus.s}, 16'h0);
        check("rst_cout", {15'h0, bus.cout}, 16'h0);
        check("rst_in_ready", {15'h0, bus.in_ready}, 16'h1);
`ifdef PIPELINED_ADDER_OVF_EN
        check("rst_ovf", {15'h0, bus.ovf}, 16'h0);
`endif
        rst = 1'b0;

        // 1: zero operands, latency of two cycles
        send(8'h00, 8'h00, 1'b0);
        check("lat_cycle1_valid", {15'h0, bus.out_valid}, 16'h0);
        tick();
        check("lat_cycle2_valid", {15'h0, bus.out_valid}, 16'h1);
        tick();
        check("after_pop_valid", {15'h0, bus.out_valid}, 16'h0);

        // 2/3: inter-stage carry and wrap, issued back-to-back
        send(8'h0F, 8'h01, 1'b0);
        send(8'h0F, 8'h00, 1'b1);
        send(8'hFF, 8'h00, 1'b1);
        send(8'hFF, 8'hFF, 1'b1);
        drain();

        // 4: stream with a three-cycle output stall on the first result
        idx = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            bus.out_ready = (cyc >= 5);
            if (idx < 4) begin
                bus.a        = ops_a[idx];
                bus.b        = ops_a[idx];
                bus.cin      = 1'b0;
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            if (cyc >= 2 && cyc <= 4) begin
                check("stall_valid", {15'h0, bus.out_valid}, 16'h1);
                check("stall_s_held", {8'h00, bus.s}, 16'h0002);
                check("stall_in_ready", {15'h0, bus.in_ready}, 16'h0);
            end
            tick();
            if (accepted) idx++;
            if (cyc >= 5 && cyc <= 8) check("no_gap", {15'h0, consumed}, 16'h1);
        end
        check("stream_all_accepted", 16'(idx), 16'd4);
        check("stream_sb_empty", 16'(sb.size()), 16'h0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;

        // 5: reset discards an in-flight op
        send(8'h10, 8'h20, 1'b0);
        rst = 1'b1;
        sb.delete();
        check("rst_mid_valid", {15'h0, bus.out_valid}, 16'h0);
        repeat (2) begin
            tick();
            check("rst_hold_valid", {15'h0, bus.out_valid}, 16'h0);
        end
        rst = 1'b0;
        repeat (3) begin
            tick();
            check("post_rst_valid", {15'h0, bus.out_valid}, 16'h0);
        end
        send(8'h55, 8'h2A, 1'b1);
        drain();

        // 6: signed overflow cases
        send(8'h7F, 8'h01, 1'b0);
        send(8'h80, 8'h80, 1'b0);
        send(8'h01, 8'hFF, 1'b0);
        drain();

        // Random operands with random input gaps and output backpressure
        for (int i = 0; i < 80; i++) begin
            bus.a         = 8'($urandom_range(0, 255));
            bus.b         = 8'($urandom_range(0, 255));
            bus.cin       = 1'($urandom_range(0, 1));
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
